// File: rtl/mont_mul_param_if.sv
// Operand-load, control and result bundle for mont_mul_param.
// The core-side driver uses the master modport and the multiplier uses the slave modport.
interface mont_mul_param_if #(
  parameter int WIDTH = 128
);
  localparam int WORDS = WIDTH / 32;
  localparam int OFFW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic             in_valid;
  logic [31:0]      in_word;
  logic [1:0]       in_operand;
  logic [OFFW-1:0]  in_offset;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             err;

  modport master (
    output in_valid, in_word, in_operand, in_offset, start,
    input  busy, result, valid, err
  );

  modport slave (
    input  in_valid, in_word, in_operand, in_offset, start,
    output busy, result, valid, err
  );
endinterface

// File: rtl/mont_mul_param.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod N.
// Operands are loaded 32 bits at a time while idle; one iteration is computed per clock.
module mont_mul_param #(
  parameter int WIDTH = 128
) (
  input logic             clk,
  input logic             rst_n,
  mont_mul_param_if.slave bus
);
  localparam int WORDS = WIDTH / 32;
  localparam int OFFW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(WIDTH) + 1;
  localparam int MW    = WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_CLEANUP = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [MW-1:0]    m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [MW-1:0]    n_ext_s;
  logic [MW-1:0]    sum_s;
  logic [MW-1:0]    red_s;
  logic [WIDTH-1:0] diff_s;

  // One iteration: add B when the current A bit is set, then add N to make the sum even.
  assign n_ext_s = {2'b00, n_q};
  assign sum_s   = m_q + (a_q[cnt_q[CW-2:0]] ? {2'b00, b_q} : {MW{1'b0}});
  assign red_s   = sum_s[0] ? (sum_s + n_ext_s) : sum_s;
  assign diff_s  = m_q[WIDTH-1:0] - n_q;

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.valid  = (state_q == ST_DONE);
  assign bus.result = res_q;
  assign bus.err    = err_q;

  // Next-state, operand-load and datapath update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          for (int w = 0; w < WORDS; w++) begin
            if (bus.in_offset == OFFW'(w)) begin
              case (bus.in_operand)
                2'd0:    a_d[w*32 +: 32] = bus.in_word;
                2'd1:    b_d[w*32 +: 32] = bus.in_word;
                2'd2:    n_d[w*32 +: 32] = bus.in_word;
                default: n_d = n_q;
              endcase
            end else begin
              n_d = n_d;
            end
          end
        end else begin
          n_d = n_q;
        end

        // The parity check sees a modulus word written in this same cycle.
        if (bus.start) begin
          if (n_d[0]) begin
            state_d = ST_RUNNING;
            m_d     = {MW{1'b0}};
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = ST_DONE;
            res_d   = {WIDTH{1'b0}};
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUNNING: begin
        m_d   = red_s >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_CLEANUP;
        end else begin
          state_d = ST_RUNNING;
        end
      end

      ST_CLEANUP: begin
        res_d   = (m_q >= n_ext_s) ? diff_s : m_q[WIDTH-1:0];
        err_d   = 1'b0;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      n_q     <= {WIDTH{1'b0}};
      m_q     <= {MW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mont_mul_param.sv
// Directed bench for mont_mul_param at WIDTH=32 and WIDTH=128.
// With N = 2^WIDTH-1, 2^WIDTH is congruent to 1 mod N, so the expected result is simply A*B mod N.
module tb_mont_mul_param;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mont_mul_param_if #(.WIDTH(32))  b32 ();
  mont_mul_param_if #(.WIDTH(128)) b128 ();

  mont_mul_param #(.WIDTH(32))  dut32  (.clk(clk), .rst_n(rst_n), .bus(b32));
  mont_mul_param #(.WIDTH(128)) dut128 (.clk(clk), .rst_n(rst_n), .bus(b128));

  task automatic wr32(input logic [1:0] op, input logic off, input logic [31:0] w);
    b32.in_valid = 1'b1; b32.in_operand = op; b32.in_offset = off; b32.in_word = w;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic wr128(input logic [1:0] op, input logic [1:0] off, input logic [31:0] w);
    b128.in_valid = 1'b1; b128.in_operand = op; b128.in_offset = off; b128.in_word = w;
    @(posedge clk); #1;
    b128.in_valid = 1'b0;
  endtask

  // lat counts edges from the one that samples start up to the edge that raises valid.
  task automatic run32(input bit wr_a, input logic [31:0] a_val, output int lat, output int nb);
    if (wr_a) begin
      b32.in_valid = 1'b1; b32.in_operand = 2'd0; b32.in_offset = 1'b0; b32.in_word = a_val;
    end
    b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0; b32.in_valid = 1'b0;
    lat = 1; nb = 0;
    while (!b32.valid && lat < 1000) begin
      if (b32.busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    if (b32.busy) nb++;
    @(posedge clk); #1;
  endtask

  task automatic run128(output int lat);
    b128.start = 1'b1;
    @(posedge clk); #1;
    b128.start = 1'b0;
    lat = 1;
    while (!b128.valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (b32.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=%h", b32.result, 32'h0); end
    checks++; if (b32.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", b32.valid); end
    checks++; if (b32.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", b32.err); end
    checks++; if (b32.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b32.busy); end
    checks++; if (b128.result !== 128'h0) begin failures++; $display("FAIL reset_result128 got=%h exp=0", b128.result); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, nb;
    wr32(2'd2, 1'b0, 32'hFFFFFFFF);
    wr32(2'd0, 1'b0, 32'h00000003);
    wr32(2'd1, 1'b0, 32'h00000005);
    run32(1'b0, 32'h0, lat, nb);
    checks++; if (lat !== 34) begin failures++; $display("FAIL basic_latency got=%0d exp=34", lat); end
    checks++; if (nb !== 34) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=34", nb); end
    checks++; if (b32.result !== 32'h0000000F) begin failures++; $display("FAIL basic_result got=%h exp=%h", b32.result, 32'h0000000F); end
    checks++; if (b32.err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", b32.err); end
    checks++; if (b32.busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", b32.busy); end
    checks++; if (b32.valid !== 1'b0) begin failures++; $display("FAIL basic_valid_pulse got=%b exp=0", b32.valid); end
  endtask

  task automatic test_vectors();
    int lat, nb;
    wr32(2'd0, 1'b0, 32'hFFFFFFFE);
    wr32(2'd1, 1'b0, 32'h00000002);
    run32(1'b0, 32'h0, lat, nb);
    checks++; if (b32.result !== 32'hFFFFFFFD) begin failures++; $display("FAIL vec_big_result got=%h exp=%h", b32.result, 32'hFFFFFFFD); end
    wr32(2'd0, 1'b0, 32'h00000000);
    wr32(2'd1, 1'b0, 32'h12345678);
    run32(1'b0, 32'h0, lat, nb);
    checks++; if (b32.result !== 32'h0) begin failures++; $display("FAIL vec_zero_result got=%h exp=0", b32.result); end
    // Operand select 3 and an out-of-range offset must both leave the operands untouched.
    wr32(2'd0, 1'b0, 32'h00000003);
    wr32(2'd1, 1'b0, 32'h00000005);
    wr32(2'd3, 1'b0, 32'h00000009);
    wr32(2'd0, 1'b1, 32'h00000007);
    run32(1'b0, 32'h0, lat, nb);
    checks++; if (b32.result !== 32'h0000000F) begin failures++; $display("FAIL ignored_write_result got=%h exp=%h", b32.result, 32'h0000000F); end
  endtask

  task automatic test_same_cycle_write();
    int lat, nb;
    run32(1'b1, 32'h00000004, lat, nb);
    checks++; if (b32.result !== 32'h00000014) begin failures++; $display("FAIL same_cycle_result got=%h exp=%h", b32.result, 32'h00000014); end
  endtask

  task automatic test_w128();
    int lat;
    wr128(2'd2, 2'd3, 32'hFFFFFFFF);
    wr128(2'd2, 2'd1, 32'hFFFFFFFF);
    wr128(2'd2, 2'd0, 32'hFFFFFFFF);
    wr128(2'd2, 2'd2, 32'hFFFFFFFF);
    wr128(2'd0, 2'd2, 32'h0);
    wr128(2'd0, 2'd0, 32'h3);
    wr128(2'd0, 2'd3, 32'h0);
    wr128(2'd0, 2'd1, 32'h0);
    wr128(2'd1, 2'd1, 32'h0);
    wr128(2'd1, 2'd0, 32'h5);
    wr128(2'd1, 2'd3, 32'h0);
    wr128(2'd1, 2'd2, 32'h0);
    run128(lat);
    checks++; if (lat !== 130) begin failures++; $display("FAIL w128_latency got=%0d exp=130", lat); end
    checks++; if (b128.result !== 128'd15) begin failures++; $display("FAIL w128_result got=%h exp=%h", b128.result, 128'd15); end
  endtask

  task automatic test_even_n();
    int lat, nb;
    wr32(2'd2, 1'b0, 32'h00000010);
    run32(1'b0, 32'h0, lat, nb);
    checks++; if (lat !== 1) begin failures++; $display("FAIL even_latency got=%0d exp=1", lat); end
    checks++; if (b32.err !== 1'b1) begin failures++; $display("FAIL even_err got=%b exp=1", b32.err); end
    checks++; if (b32.result !== 32'h0) begin failures++; $display("FAIL even_result got=%h exp=0", b32.result); end
    wr32(2'd2, 1'b0, 32'hFFFFFFFF);
    wr32(2'd0, 1'b0, 32'h00000003);
    run32(1'b0, 32'h0, lat, nb);
    checks++; if (b32.err !== 1'b0) begin failures++; $display("FAIL odd_after_even_err got=%b exp=0", b32.err); end
    checks++; if (b32.result !== 32'h0000000F) begin failures++; $display("FAIL odd_after_even_result got=%h exp=%h", b32.result, 32'h0000000F); end
  endtask

  task automatic test_busy_ignore();
    int pulses;
    logic [31:0] got;
    pulses = 0; got = 32'h0;
    b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 5) begin
        b32.in_valid = 1'b1; b32.in_operand = 2'd0; b32.in_offset = 1'b0; b32.in_word = 32'h0;
        b32.start = 1'b1;
      end else begin
        b32.in_valid = 1'b0; b32.start = 1'b0;
      end
      if (b32.valid) begin pulses++; got = b32.result; end
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); end
    checks++; if (got !== 32'h0000000F) begin failures++; $display("FAIL busy_ignore_result got=%h exp=%h", got, 32'h0000000F); end
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (b32.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", b32.busy); end
    checks++; if (b32.valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", b32.valid); end
    checks++; if (b32.result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=0", b32.result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run32(1'b0, 32'h0, lat, nb);
    checks++; if (lat !== 1) begin failures++; $display("FAIL cleared_n_latency got=%0d exp=1", lat); end
    checks++; if (b32.err !== 1'b1) begin failures++; $display("FAIL cleared_n_err got=%b exp=1", b32.err); end
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.in_word = 32'h0; b32.in_operand = 2'd0; b32.in_offset = 1'b0; b32.start = 1'b0;
    b128.in_valid = 1'b0; b128.in_word = 32'h0; b128.in_operand = 2'd0; b128.in_offset = 2'd0; b128.start = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_same_cycle_write();
    test_w128();
    test_even_n();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
